// File: rtl/csr_apb_pkg.sv
// Shared constants and FSM encoding for the ALU CSR APB sequencer.
package csr_apb_pkg;

  localparam int unsigned ADDR_CTRL   = 'h00;
  localparam int unsigned ADDR_DATA0  = 'h04;
  localparam int unsigned ADDR_DATA1  = 'h08;
  localparam int unsigned ADDR_RESULT = 'h0C;
  localparam int unsigned ADDR_STATUS = 'h10;

  localparam int unsigned START_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    PUSH_WAIT,
    RD_WAIT,
    RD_DONE
  } state_t;

endpackage

// File: rtl/csr_wait_counter.sv
// Clearable up-counter with a terminal-count compare, shared by the push-timeout and read-latency paths.
module csr_wait_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/csr_apb_sequencer.sv
// APB slave controller for the ALU CSR bank: register enables, FIFO_IN push and FIFO_OUT pop sequencing.
module csr_apb_sequencer
  import csr_apb_pkg::*;
#(
  parameter int APB_BUS_SIZE   = 32,
  parameter int ADDR_SIZE      = 5,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int PUSH_TIMEOUT   = 16,
  parameter int RD_LAT         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_SIZE-1:0]      paddr,
  input  logic [APB_BUS_SIZE-1:0]   pwdata,
  output logic [APB_BUS_SIZE-1:0]   prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic                      full_in,
  input  logic                      empty_out,
  input  logic [FIFO_OUT_WIDTH-1:0] final_result,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
  output logic                      en_ctrl,
  output logic                      en_data0,
  output logic                      en_data1,
  output logic                      w_en_in,
  output logic                      r_en_out
);

  localparam int CNT_MAX = (PUSH_TIMEOUT > RD_LAT) ? PUSH_TIMEOUT : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t                  state, state_nxt;
  logic [APB_BUS_SIZE-1:0] rdata_q;
  logic                    done_q;
  logic                    capture;
  logic                    cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0]        cnt_term;
  logic                    access;
  logic                    hit_ctrl, hit_data0, hit_data1, hit_result, hit_status;
  logic                    unused_pwdata;

  assign unused_pwdata = ^pwdata;

  assign hit_ctrl   = (paddr == ADDR_SIZE'(ADDR_CTRL));
  assign hit_data0  = (paddr == ADDR_SIZE'(ADDR_DATA0));
  assign hit_data1  = (paddr == ADDR_SIZE'(ADDR_DATA1));
  assign hit_result = (paddr == ADDR_SIZE'(ADDR_RESULT));
  assign hit_status = (paddr == ADDR_SIZE'(ADDR_STATUS));

  // done_q masks a held access phase after completion so strobes never re-fire
  assign access = psel && penable && !done_q;

  csr_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .term(cnt_term),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rdata_q <= APB_BUS_SIZE'(final_result);
      end
      if (!(psel && penable)) begin
        done_q <= 1'b0;
      end else if (pready) begin
        done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    en_ctrl   = 1'b0;
    en_data0  = 1'b0;
    en_data1  = 1'b0;
    w_en_in   = 1'b0;
    r_en_out  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_term  = CNT_W'(PUSH_TIMEOUT - 1);
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (pwrite) begin
            if (hit_ctrl) begin
              en_ctrl = 1'b1;
              if (pwdata[START_BIT]) begin
                cnt_clr   = 1'b1;
                state_nxt = PUSH_WAIT;
              end else begin
                pready = 1'b1;
              end
            end else if (hit_data0) begin
              en_data0 = 1'b1;
              pready   = 1'b1;
            end else if (hit_data1) begin
              en_data1 = 1'b1;
              pready   = 1'b1;
            end else begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end
          end else if (hit_result) begin
            if (empty_out) begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end else begin
              r_en_out  = 1'b1;
              cnt_clr   = 1'b1;
              state_nxt = RD_WAIT;
            end
          end else if (hit_status) begin
            pready = 1'b1;
            prdata = APB_BUS_SIZE'(fifo_out_status);
          end else if (hit_ctrl || hit_data0 || hit_data1) begin
            pready = 1'b1;
          end else begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end
        end
      end
      PUSH_WAIT: begin
        if (!full_in) begin
          w_en_in   = 1'b1;
          pready    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_tc) begin
          // timed out: start bit stays set in CTRL, software must rewrite it
          pready    = 1'b1;
          pslverr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD_WAIT: begin
        cnt_term = CNT_W'(RD_LAT - 1);
        cnt_inc  = 1'b1;
        if (cnt_tc) begin
          capture   = 1'b1;
          state_nxt = RD_DONE;
        end
      end
      RD_DONE: begin
        pready    = 1'b1;
        prdata    = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      en_ctrl   = 1'b0;
      en_data0  = 1'b0;
      en_data1  = 1'b0;
      w_en_in   = 1'b0;
      r_en_out  = 1'b0;
      capture   = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_apb_sequencer.sv
// Scoreboard bench for csr_apb_sequencer: directed APB transfers, monitor checks responses and strobe counts.
module tb_csr_apb_sequencer;

  localparam int RD_LAT = 2;
  localparam int PUSH_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        full_in, empty_out;
  logic [24:0] final_result, fifo_out_status;
  logic        en_ctrl, en_data0, en_data1, w_en_in, r_en_out;

  csr_apb_sequencer #(
    .APB_BUS_SIZE(32), .ADDR_SIZE(5), .FIFO_OUT_WIDTH(25),
    .PUSH_TIMEOUT(PUSH_TIMEOUT), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .full_in(full_in), .empty_out(empty_out),
    .final_result(final_result), .fifo_out_status(fifo_out_status),
    .en_ctrl(en_ctrl), .en_data0(en_data0), .en_data1(en_data1),
    .w_en_in(w_en_in), .r_en_out(r_en_out)
  );

  always #5 clk = ~clk;

  // FIFO_OUT model: result register valid exactly RD_LAT cycles after the pop
  logic [1:0] ren_d = 2'b00;
  always @(posedge clk) ren_d <= {ren_d[0], r_en_out};
  always_comb final_result = ren_d[1] ? 25'h1ABCDEF : 25'h0555555;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    int          n_ctrl, n_d0, n_d1, n_wen, n_ren;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] rd, logic er, int w, int c, int d0, int d1, int we, int re);
    exp_t e;
    e.rdata = rd; e.err = er; e.waits = w;
    e.n_ctrl = c; e.n_d0 = d0; e.n_d1 = d1; e.n_wen = we; e.n_ren = re;
    return e;
  endfunction

  // Monitor: accumulate strobes and wait states, compare at each completed transfer
  int acc_w, acc_c, acc_d0, acc_d1, acc_we, acc_re;
  always @(negedge clk) begin
    exp_t e;
    chk("err_without_ready", 32'(pslverr & ~pready), 32'h0);
    chk("push_pop_overlap", 32'(w_en_in & r_en_out), 32'h0);
    if (!pready || pwrite) chk("prdata_idle_zero", prdata, 32'h0);
    if (rst) begin
      acc_w = 0; acc_c = 0; acc_d0 = 0; acc_d1 = 0; acc_we = 0; acc_re = 0;
    end else begin
      acc_c  += int'(en_ctrl);
      acc_d0 += int'(en_data0);
      acc_d1 += int'(en_data1);
      acc_we += int'(w_en_in);
      acc_re += int'(r_en_out);
      if (psel && penable && !pready) acc_w++;
      if (psel && penable && pready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("prdata", prdata, e.rdata);
          chk("pslverr", 32'(pslverr), 32'(e.err));
          chk("wait_states", acc_w, e.waits);
          chk("en_ctrl_pulses", acc_c, e.n_ctrl);
          chk("en_data0_pulses", acc_d0, e.n_d0);
          chk("en_data1_pulses", acc_d1, e.n_d1);
          chk("w_en_in_pulses", acc_we, e.n_wen);
          chk("r_en_out_pulses", acc_re, e.n_ren);
        end
        acc_w = 0; acc_c = 0; acc_d0 = 0; acc_d1 = 0; acc_we = 0; acc_re = 0;
      end
    end
  end

  task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] data, input exp_t e);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n > 100) begin
        chk("pready_timeout", 32'h0, 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_prdata"}, prdata, 32'h0);
    chk({tag, "_pready"}, 32'(pready), 32'h0);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'h0);
    chk({tag, "_strobes"}, 32'({en_ctrl, en_data0, en_data1, w_en_in, r_en_out}), 32'h0);
  endtask

  // Abort a transfer in its wait phase; access phase stays asserted during rst
  task automatic rst_mid(input bit rd);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = !rd;
    paddr = rd ? 5'h0C : 5'h00; pwdata = 32'h1; full_in = 1'b1; empty_out = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; full_in = 1'b0;
    @(negedge clk);
    chk_all_zero(rd ? "rst_rdwait" : "rst_pushwait");
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk_all_zero(rd ? "post_rst_rdwait" : "post_rst_pushwait");
  endtask

  initial begin
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h04;
    pwdata = 32'h1234; full_in = 1'b0; empty_out = 1'b1; fifo_out_status = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

    apb_xfer(1, 5'h04, 32'h0000_1234, mk(32'h0, 0, 0, 0, 1, 0, 0, 0));
    apb_xfer(1, 5'h08, 32'h0000_00AB, mk(32'h0, 0, 0, 0, 0, 1, 0, 0));
    apb_xfer(1, 5'h00, 32'h0000_0103, mk(32'h0, 0, 1, 1, 0, 0, 1, 0));
    apb_xfer(1, 5'h00, 32'h0000_0102, mk(32'h0, 0, 0, 1, 0, 0, 0, 0));

    full_in = 1'b1;
    fork
      apb_xfer(1, 5'h00, 32'h0000_0001, mk(32'h0, 0, 5, 1, 0, 0, 1, 0));
      begin
        wait (penable === 1'b1);
        repeat (5) @(posedge clk);
        #1 full_in = 1'b0;
      end
    join

    full_in = 1'b1;
    apb_xfer(1, 5'h00, 32'h0000_0001, mk(32'h0, 1, PUSH_TIMEOUT, 1, 0, 0, 0, 0));
    full_in = 1'b0;

    empty_out = 1'b0;
    apb_xfer(0, 5'h0C, 32'h0, mk(32'h01AB_CDEF, 0, RD_LAT + 1, 0, 0, 0, 0, 1));
    empty_out = 1'b1;
    apb_xfer(0, 5'h0C, 32'h0, mk(32'h0, 1, 0, 0, 0, 0, 0, 0));

    fifo_out_status = 25'h2;
    apb_xfer(0, 5'h10, 32'h0, mk(32'h0000_0002, 0, 0, 0, 0, 0, 0, 0));
    apb_xfer(1, 5'h14, 32'hFFFF_FFFF, mk(32'h0, 1, 0, 0, 0, 0, 0, 0));
    apb_xfer(1, 5'h0C, 32'h1, mk(32'h0, 1, 0, 0, 0, 0, 0, 0));
    apb_xfer(0, 5'h00, 32'h0, mk(32'h0, 0, 0, 0, 0, 0, 0, 0));

    rst_mid(0);
    rst_mid(1);
    empty_out = 1'b1;
    apb_xfer(1, 5'h04, 32'h0000_5A5A, mk(32'h0, 0, 0, 0, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
